// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// ---------------------------------------------------------------------------
// Control and timekeeping stage for an MM:SS stopwatch.
// Functions:
//   - Conditions the two raw push-buttons (2-FF synchroniser, debounce,
//     one-cycle press pulse).
//   - Drives the 1-second prescaler's enable and clear.
//   - Accumulates elapsed seconds as four BCD digits from the prescaler tick.
//
// Ports:
//   clk       in   system clock (100 MHz)
//   rst       in   synchronous, active-high reset
//   btn_ss    in   raw start/stop button (asynchronous, active-high)
//   btn_clr   in   raw clear button (asynchronous, active-high)
//   tick      in   one-cycle 1 Hz pulse from the prescaler
//   cnt_en    out  prescaler enable, high while the FSM is in RUN
//   cnt_clr   out  one-cycle synchronous clear to the prescaler
//   sec_ones  out  BCD seconds units (0-9)
//   sec_tens  out  BCD seconds tens (0-5)
//   min_ones  out  BCD minutes units (0-9)
//   min_tens  out  BCD minutes tens (0-9)
//   state     out  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 HALT
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int DEB_CYCLES = 2_000_000,
  parameter int DEB_W      = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_clr,
  input  logic       tick,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [1:0] state
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_HALT  = 2'b11;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  // Button vectors: bit 0 = start/stop, bit 1 = clear.
  logic [1:0]       meta_q, meta_d;
  logic [1:0]       sync_q, sync_d;
  logic [1:0]       level_q, level_d;
  logic [1:0]       level_prev_q, level_prev_d;
  logic [1:0]       press_q, press_d;
  logic [DEB_W-1:0] deb_cnt_q [2];
  logic [DEB_W-1:0] deb_cnt_d [2];

  logic [1:0] state_q, state_d;
  logic       cnt_clr_q, cnt_clr_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] min_tens_q, min_tens_d;

  logic ss_press_s, clr_press_s, at_max_s, count_s;

  // Button conditioning: synchroniser, debounce counter, rising-edge pulse.
  always_comb begin
    meta_d       = {btn_clr, btn_ss};
    sync_d       = meta_q;
    level_d      = level_q;
    level_prev_d = level_q;
    // Pulse fires one cycle after the debounced level rises; releases are ignored.
    press_d      = level_q & ~level_prev_q;
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = '0;
      if (sync_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          level_d[i] = sync_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end else begin
        deb_cnt_d[i] = '0;
      end
    end
  end

  assign ss_press_s  = press_q[0];
  assign clr_press_s = press_q[1];
  assign at_max_s    = (min_tens_q == 4'd9) && (min_ones_q == 4'd9) &&
                       (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);
  // Ticks only count while the registered state is RUN.
  assign count_s     = tick && (state_q == ST_RUN);

  // FSM next state, prescaler clear and BCD ripple-carry time accumulation.
  always_comb begin
    state_d    = state_q;
    cnt_clr_d  = 1'b0;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    if (clr_press_s) begin
      // Clear wins over start/stop and tick in the same cycle.
      state_d    = ST_IDLE;
      cnt_clr_d  = 1'b1;
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ss_press_s ? ST_RUN : ST_IDLE;
        ST_RUN:   state_d = ss_press_s ? ST_PAUSE : ST_RUN;
        ST_PAUSE: state_d = ss_press_s ? ST_RUN : ST_PAUSE;
        ST_HALT:  state_d = ST_HALT;
        default:  state_d = ST_IDLE;
      endcase
      if (count_s) begin
        if (at_max_s) begin
          // Saturate at 99:59 rather than wrapping.
          state_d = ST_HALT;
        end else if (sec_ones_q != 4'd9) begin
          sec_ones_d = sec_ones_q + 4'd1;
        end else begin
          sec_ones_d = 4'd0;
          if (sec_tens_q != 4'd5) begin
            sec_tens_d = sec_tens_q + 4'd1;
          end else begin
            sec_tens_d = 4'd0;
            if (min_ones_q != 4'd9) begin
              min_ones_d = min_ones_q + 4'd1;
            end else begin
              min_ones_d = 4'd0;
              min_tens_d = min_tens_q + 4'd1;
            end
          end
        end
      end else begin
        sec_ones_d = sec_ones_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q       <= 2'b00;
      sync_q       <= 2'b00;
      level_q      <= 2'b00;
      level_prev_q <= 2'b00;
      press_q      <= 2'b00;
      deb_cnt_q[0] <= '0;
      deb_cnt_q[1] <= '0;
      state_q      <= ST_IDLE;
      cnt_clr_q    <= 1'b0;
      sec_ones_q   <= 4'd0;
      sec_tens_q   <= 4'd0;
      min_ones_q   <= 4'd0;
      min_tens_q   <= 4'd0;
    end else begin
      meta_q       <= meta_d;
      sync_q       <= sync_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      press_q      <= press_d;
      deb_cnt_q[0] <= deb_cnt_d[0];
      deb_cnt_q[1] <= deb_cnt_d[1];
      state_q      <= state_d;
      cnt_clr_q    <= cnt_clr_d;
      sec_ones_q   <= sec_ones_d;
      sec_tens_q   <= sec_tens_d;
      min_ones_q   <= min_ones_d;
      min_tens_q   <= min_tens_d;
    end
  end

  assign cnt_en   = (state_q == ST_RUN);
  assign cnt_clr  = cnt_clr_q;
  assign state    = state_q;
  assign sec_ones = sec_ones_q;
  assign sec_tens = sec_tens_q;
  assign min_ones = min_ones_q;
  assign min_tens = min_tens_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
// Directed-vector bench for stopwatch_ctrl with DEB_CYCLES=4. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_ss = 1'b0;
  logic       btn_clr = 1'b0;
  logic       tick = 1'b0;
  logic       cnt_en, cnt_clr;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;
  int clr_pulses = 0;
  int cyc;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DEB_CYCLES(4), .DEB_W(3)) dut (
    .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_clr(btn_clr), .tick(tick),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens), .state(state)
  );

  // Count cycles with the prescaler clear asserted.
  always @(negedge clk) begin
    if (cnt_clr) clr_pulses++;
  end

  function automatic logic [15:0] digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_btn(input bit is_clr);
    if (is_clr) btn_clr = 1'b1; else btn_ss = 1'b1;
    repeat (10) @(negedge clk);
    btn_clr = 1'b0;
    btn_ss  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_state", state, 2'b00);
    check_eq("rst_digits", digits(), 16'h0000);
    check_eq("rst_en", cnt_en, 1'b0);
    check_eq("rst_clr", cnt_clr, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Held start/stop: one press, IDLE->RUN after 2+4+1+1 cycles
    btn_ss = 1'b1;
    cyc = 0;
    while (state != 2'b01 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("ss_latency", cyc, 8);
    repeat (10 - cyc) @(negedge clk);
    btn_ss = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("hold_one_press", state, 2'b01);
    check_eq("run_en", cnt_en, 1'b1);

    // 2-cycle glitch is filtered
    btn_ss = 1'b1;
    repeat (2) @(negedge clk);
    btn_ss = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("glitch_state", state, 2'b01);

    // Accumulation and carries
    ticks(61);
    check_eq("t61", digits(), 16'h0101);
    ticks(538);
    check_eq("t0959", digits(), 16'h0959);
    ticks(1);
    check_eq("t1000", digits(), 16'h1000);
    ticks(5398);
    check_eq("t9958", digits(), 16'h9958);
    ticks(1);
    check_eq("t9959", digits(), 16'h9959);
    check_eq("t9959_state", state, 2'b01);
    ticks(1);
    check_eq("halt_state", state, 2'b11);
    check_eq("halt_digits", digits(), 16'h9959);
    check_eq("halt_en", cnt_en, 1'b0);
    ticks(5);
    press_btn(1'b0);
    check_eq("halt_hold_state", state, 2'b11);
    check_eq("halt_hold_digits", digits(), 16'h9959);

    // Clear from HALT
    clr_pulses = 0;
    press_btn(1'b1);
    check_eq("clr_state", state, 2'b00);
    check_eq("clr_digits", digits(), 16'h0000);
    check_eq("clr_pulses", clr_pulses, 1);

    // Pause and resume
    press_btn(1'b0);
    ticks(7);
    check_eq("t0007", digits(), 16'h0007);
    press_btn(1'b0);
    check_eq("pause_state", state, 2'b10);
    check_eq("pause_en", cnt_en, 1'b0);
    ticks(4);
    check_eq("pause_hold", digits(), 16'h0007);
    press_btn(1'b0);
    check_eq("resume_state", state, 2'b01);
    check_eq("resume_en", cnt_en, 1'b1);
    ticks(1);
    check_eq("t0008", digits(), 16'h0008);
    ticks(22);
    check_eq("t0030", digits(), 16'h0030);

    // Clear, start/stop and tick all land in the same cycle
    clr_pulses = 0;
    btn_ss  = 1'b1;
    btn_clr = 1'b1;
    repeat (7) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check_eq("combo_state", state, 2'b00);
    check_eq("combo_digits", digits(), 16'h0000);
    check_eq("combo_clr_hi", cnt_clr, 1'b1);
    @(negedge clk);
    check_eq("combo_clr_lo", cnt_clr, 1'b0);
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("combo_pulses", clr_pulses, 1);
    check_eq("combo_idle", state, 2'b00);

    // Reset mid-run at 12:34
    press_btn(1'b0);
    ticks(754);
    check_eq("t1234", digits(), 16'h1234);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mrst_state", state, 2'b00);
    check_eq("mrst_digits", digits(), 16'h0000);
    check_eq("mrst_en", cnt_en, 1'b0);
    check_eq("mrst_clr", cnt_clr, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
